// File: rtl/tone_period_meter.sv
// tone_period_meter: measures half-periods of an asynchronous square wave,
// locks onto in-range tones and reports the sweep direction between measurements.
module tone_period_meter #(
   parameter int CNT_W    = 16,
   parameter int MIN_HALF = 8193,
   parameter int MAX_HALF = 16321,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             tone_present,
   output logic [1:0]       trend
);
   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LO      = CNT_W'(MIN_HALF);
   localparam logic [CNT_W-1:0] HI      = CNT_W'(MAX_HALF);
   localparam logic [4:0]       LOCK    = 5'(LOCK_CNT);

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q, tgl, in_range;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, m;
   logic [4:0]       good_q, good_d, good_inc;
   logic             valid_q, valid_d, prev_q, prev_d;
   logic [1:0]       trend_q, trend_d;

   always_comb begin
      tgl      = s2_q ^ s3_q;
      // m doubles as the saturating counter increment
      m        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      in_range = (m >= LO) && (m <= HI);
      good_inc = good_q + 5'd1;
      cnt_d    = tgl ? '0 : m;
      state_d  = state_q;
      period_d = period_q;
      valid_d  = 1'b0;
      trend_d  = trend_q;
      good_d   = good_q;
      prev_d   = prev_q;
      if (state_q == IDLE) begin
         if (tgl) begin
            state_d = MEASURE;
            prev_d  = 1'b0;
         end
      end else if (tgl) begin
         period_d = m;
         valid_d  = 1'b1;
         prev_d   = 1'b1;
         trend_d  = !prev_q ? 2'b00 : (m > period_q) ? 2'b01 : (m < period_q) ? 2'b10 : 2'b00;
         good_d   = !in_range ? 5'd0 : (good_inc >= LOCK) ? LOCK : good_inc;
         state_d  = (in_range && good_inc >= LOCK) ? LOCKED : MEASURE;
      end else if (cnt_q == CNT_MAX) begin
         state_d = IDLE;
         good_d  = 5'd0;
         trend_d = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         period_q <= '0;
         valid_q  <= 1'b0;
         trend_q  <= 2'b00;
         good_q   <= 5'd0;
         prev_q   <= 1'b0;
      end else begin
         s1_q     <= tone_in;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         trend_q  <= trend_d;
         good_q   <= good_d;
         prev_q   <= prev_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign tone_present = (state_q == LOCKED);
   assign trend        = trend_q;
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: scoreboard bench; a transaction-level model predicts
// each measurement pulse when the tone toggles, the monitor compares pulses.
module tb_tone_period_meter;
   localparam int CNT_W    = 12;
   localparam int MIN_HALF = 513;
   localparam int MAX_HALF = 1020;
   localparam int LOCK_CNT = 4;
   localparam int CMAX     = (1 << CNT_W) - 1;

   typedef struct {int p; int t; int pr;} exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             tone_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_valid, tone_present;
   logic [1:0]       trend;

   int   tests = 0, fails = 0, cyc = 0, last = 0;
   int   mst = 0, good = 0, prev = 0, have = 0;
   logic pv_q = 1'b0;
   exp_t q[$];
   exp_t e_m;

   tone_period_meter #(
      .CNT_W(CNT_W), .MIN_HALF(MIN_HALF), .MAX_HALF(MAX_HALF), .LOCK_CNT(LOCK_CNT)
   ) dut (
      .clk(clk), .reset(reset), .tone_in(tone_in), .period(period),
      .period_valid(period_valid), .tone_present(tone_present), .trend(trend)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // n = clocks since the previous edge of tone_in
   task automatic model(input int n);
      int m, tr;
      if (mst != 0 && n > CMAX + 1) begin
         mst  = 0;
         good = 0;
      end
      if (mst == 0) begin
         mst  = 1;
         have = 0;
         return;
      end
      m  = (n > CMAX) ? CMAX : n;
      tr = !have ? 0 : (m > prev) ? 1 : (m < prev) ? 2 : 0;
      if (m >= MIN_HALF && m <= MAX_HALF) begin
         good = (good + 1 > LOCK_CNT) ? LOCK_CNT : good + 1;
         mst  = (good >= LOCK_CNT) ? 2 : 1;
      end else begin
         good = 0;
         mst  = 1;
      end
      q.push_back('{m, tr, (mst == 2) ? 1 : 0});
      prev = m;
      have = 1;
   endtask

   task automatic tog(input int n);
      tone_in = ~tone_in;
      model(cyc - last);
      last = cyc;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      pv_q <= period_valid;
      if (!reset && period_valid) begin
         if (period_valid && pv_q) check("double_pulse", 1, 0);
         if (q.size() == 0) check("spurious_pulse", 1, 0);
         else begin
            e_m = q.pop_front();
            check("period", 32'(period), e_m.p);
            check("trend", 32'(trend), e_m.t);
            check("present", 32'(tone_present), e_m.pr);
         end
      end
   end

   initial begin
      int bnd[10];
      int swp[5];
      bnd = '{512, 513, 513, 513, 513, 1021, 1020, 1020, 1020, 1020};
      swp = '{516, 520, 524, 528, 532};
      repeat (3) @(posedge clk);
      #1;
      check("rst_period", 32'(period), 0);
      check("rst_valid", 32'(period_valid), 0);
      check("rst_present", 32'(tone_present), 0);
      check("rst_trend", 32'(trend), 0);
      reset = 1'b0;
      last = cyc;
      repeat (5) tog(625);
      check("lock_625", 32'(tone_present), 1);
      tog(312);
      repeat (5) tog(625);
      check("relock_625", 32'(tone_present), 1);
      foreach (bnd[i]) tog(bnd[i]);
      tog(625);
      foreach (swp[i]) tog(swp[i]);
      repeat (5) tog(750);
      check("lock_750", 32'(tone_present), 1);
      tone_in = ~tone_in;
      model(cyc - last);
      last = cyc;
      repeat (3000) @(posedge clk);
      #1;
      check("hold_present", 32'(tone_present), 1);
      repeat (1300) @(posedge clk);
      #1;
      check("timeout_present", 32'(tone_present), 0);
      check("timeout_trend", 32'(trend), 0);
      check("timeout_period", 32'(period), 750);
      repeat (6) tog(750);
      if (tone_in == 1'b0) tog(750);
      repeat (300) @(posedge clk);
      #1;
      check("pre_rst_present", 32'(tone_present), 1);
      check("pre_rst_pending", q.size(), 0);
      reset = 1'b1;
      #1;
      check("mid_rst_period", 32'(period), 0);
      check("mid_rst_present", 32'(tone_present), 0);
      check("mid_rst_trend", 32'(trend), 0);
      check("mid_rst_valid", 32'(period_valid), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mst  = 0;
      good = 0;
      model(0);
      last = cyc;
      repeat (300) @(posedge clk);
      #1;
      tone_in = 1'b1;
      repeat (5) tog(625);
      repeat (10) @(posedge clk);
      #1;
      check("pending", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
